qs_stream_chk: RTL and testbench



---
 rtl/qs_chk_pkg.sv | 45 ++++
 rtl/qs_chk_fifo.sv | 91 +++++++++
 rtl/qs_stream_chk.sv | 256 +++++++++++++++++++++++++
 tb/tb_qs_stream_chk.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/qs_chk_pkg.sv
// Shared types for the quicksort stream checker: verdict codes, FIFO descriptor
// and the saturating length increment used by both packet trackers.
package qs_chk_pkg;

   localparam int unsigned CHK_W     = 32;
   localparam int unsigned CHK_LEN_W = 16;
   localparam int unsigned CHK_SUM_W = CHK_W + CHK_LEN_W;

   localparam logic [CHK_LEN_W-1:0] LEN_ONE = CHK_LEN_W'(1);

   typedef enum logic [2:0] {
      ERR_OK     = 3'd0,
      ERR_ORDER  = 3'd1,
      ERR_LEN    = 3'd2,
      ERR_SUM    = 3'd3,
      ERR_FRAME  = 3'd4,
      ERR_UNEXP  = 3'd5,
      ERR_OVF    = 3'd6,
      ERR_DUTERR = 3'd7
   } err_t;

   typedef struct packed {
      logic [CHK_LEN_W-1:0] len;
      logic [CHK_SUM_W-1:0] sum;
   } desc_t;

   typedef enum logic {
      I_IDLE = 1'b0,
      I_PKT  = 1'b1
   } in_state_t;

   typedef enum logic {
      O_IDLE = 1'b0,
      O_PKT  = 1'b1
   } out_state_t;

   function automatic logic [CHK_LEN_W-1:0] len_inc(input logic [CHK_LEN_W-1:0] len);
      if (&len) begin
         return len;
      end else begin
         return len + LEN_ONE;
      end
   endfunction

endpackage

// File: rtl/qs_chk_fifo.sv
// Descriptor FIFO for input packets awaiting their sorted counterpart.
// The head is kept in a register so the verdict compare sees a flop output.
module qs_chk_fifo
   import qs_chk_pkg::*;
#(
   parameter int unsigned DEPTH = 4
)(
   input  logic  clk,
   input  logic  rst,
   input  logic  push,
   input  desc_t din,
   input  logic  pop,
   output logic  full,
   output logic  empty,
   output desc_t head
);

   localparam int unsigned   AW      = $clog2(DEPTH);
   localparam logic [AW:0]   PTR_ONE = (AW+1)'(1);
   localparam logic [AW-1:0] IDX_ONE = AW'(1);

   desc_t         mem_r [DEPTH];
   desc_t         head_r;
   desc_t         head_nxt_s;
   logic [AW:0]   wr_ptr_r;
   logic [AW:0]   rd_ptr_r;
   logic [AW-1:0] rd_nxt_idx_s;
   logic          empty_s;
   logic          full_s;
   logic          do_push_s;
   logic          do_pop_s;
   logic          count_one_s;

   assign empty_s      = (wr_ptr_r == rd_ptr_r);
   assign full_s       = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                         (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
   assign do_pop_s     = pop & ~empty_s;
   // A full FIFO still accepts a push when the same cycle frees a slot.
   assign do_push_s    = push & (~full_s | do_pop_s);
   assign count_one_s  = ((wr_ptr_r - rd_ptr_r) == PTR_ONE);
   assign rd_nxt_idx_s = rd_ptr_r[AW-1:0] + IDX_ONE;

   // Next head: the entry behind the popped one, or a push into an emptying FIFO.
   always_comb begin
      head_nxt_s = head_r;
      if (do_pop_s) begin
         if (count_one_s) begin
            if (do_push_s) begin
               head_nxt_s = din;
            end else begin
               head_nxt_s = head_r;
            end
         end else begin
            head_nxt_s = mem_r[rd_nxt_idx_s];
         end
      end else if (empty_s && do_push_s) begin
         head_nxt_s = din;
      end else begin
         head_nxt_s = head_r;
      end
   end

   // Pointer and head registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         head_r   <= '0;
      end else begin
         if (do_push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         if (do_pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
         head_r <= head_nxt_s;
      end
   end

   // Descriptor storage.
   always_ff @(posedge clk) begin
      if (do_push_s) begin
         mem_r[wr_ptr_r[AW-1:0]] <= din;
      end
   end

   assign full  = full_s;
   assign empty = empty_s;
   assign head  = head_r;

endmodule

// File: rtl/qs_stream_chk.sv
// Passive checker for the quicksort engine: records each input packet's length
// and sum, then validates framing, order, length and sum of each output packet.
module qs_stream_chk
   import qs_chk_pkg::*;
#(
   parameter int unsigned W      = CHK_W,
   parameter int unsigned LEN_W  = CHK_LEN_W,
   parameter int unsigned DEPTH  = 4,
   parameter bit          ASCEND = 1'b1
)(
   input  logic         clk,
   input  logic         rst,
   input  logic         in_vld,
   input  logic         in_sop,
   input  logic         in_eop,
   input  logic [W-1:0] in_dat,
   input  logic         in_rdy_r,
   input  logic         out_vld_r,
   input  logic         out_sop_r,
   input  logic         out_eop_r,
   input  logic         out_err_r,
   input  logic [W-1:0] out_dat_r,
   output logic         chk_pass_r,
   output logic         chk_fail_r,
   output logic [2:0]   chk_code_r,
   output logic [31:0]  chk_pkt_cnt_r,
   output logic         chk_busy_r
);

   localparam int unsigned SUM_W = W + LEN_W;

   // Input tracker
   in_state_t        in_state_r;
   logic [LEN_W-1:0] in_len_r;
   logic [SUM_W-1:0] in_sum_r;
   logic [LEN_W-1:0] in_len_nxt_s;
   logic [SUM_W-1:0] in_sum_nxt_s;
   logic             in_acc_s;
   logic             in_live_s;
   logic             in_push_s;
   logic             in_frame_s;
   logic             in_ovf_s;
   logic             in_err_vld_s;
   err_t             in_err_code_s;
   desc_t            push_desc_s;

   // Output tracker
   out_state_t       o_state_r;
   logic [LEN_W-1:0] o_len_r;
   logic [SUM_W-1:0] o_sum_r;
   logic [W-1:0]     o_prev_r;
   logic             o_ord_r;
   logic             o_dut_r;
   logic [LEN_W-1:0] o_len_nxt_s;
   logic [SUM_W-1:0] o_sum_nxt_s;
   logic             o_ord_nxt_s;
   logic             o_dut_nxt_s;
   logic             o_viol_s;
   logic             o_frame_s;
   logic             o_end_s;
   logic             o_vld_s;
   err_t             o_code_s;

   // FIFO and verdict arbitration
   logic             pop_s;
   logic             fifo_full_s;
   logic             fifo_empty_s;
   desc_t            fifo_head_s;
   logic             pend_vld_r;
   err_t             pend_code_r;

   // Input beat decode: accumulator values after this beat and side-band errors.
   always_comb begin
      in_acc_s  = in_vld & in_rdy_r;
      in_live_s = in_sop | (in_state_r == I_PKT);
      if (in_sop) begin
         in_len_nxt_s = LEN_ONE;
         in_sum_nxt_s = SUM_W'(in_dat);
      end else begin
         in_len_nxt_s = len_inc(in_len_r);
         in_sum_nxt_s = in_sum_r + SUM_W'(in_dat);
      end
      in_push_s  = in_acc_s & in_eop & in_live_s;
      // sop inside a packet, or a headless beat, are both framing faults.
      in_frame_s = in_acc_s & ((in_state_r == I_PKT) == in_sop);
      in_ovf_s   = in_push_s & fifo_full_s & ~pop_s;
      in_err_vld_s = in_frame_s | in_ovf_s;
      if (in_ovf_s) begin
         in_err_code_s = ERR_OVF;
      end else begin
         in_err_code_s = ERR_FRAME;
      end
      push_desc_s.len = in_len_nxt_s;
      push_desc_s.sum = in_sum_nxt_s;
   end

   // Input FSM: a restart on sop drops the partial packet.
   always_ff @(posedge clk) begin
      if (rst) begin
         in_state_r <= I_IDLE;
         in_len_r   <= '0;
         in_sum_r   <= '0;
      end else begin
         case (in_state_r)
            I_IDLE: begin
               if (in_acc_s && in_sop) begin
                  in_len_r   <= in_len_nxt_s;
                  in_sum_r   <= in_sum_nxt_s;
                  in_state_r <= in_eop ? I_IDLE : I_PKT;
               end
            end
            I_PKT: begin
               if (in_acc_s) begin
                  in_len_r   <= in_len_nxt_s;
                  in_sum_r   <= in_sum_nxt_s;
                  in_state_r <= in_eop ? I_IDLE : I_PKT;
               end
            end
            default: in_state_r <= I_IDLE;
         endcase
      end
   end

   // Output beat decode and verdict code, checks in priority order.
   always_comb begin
      if (ASCEND) begin
         o_viol_s = (out_dat_r < o_prev_r);
      end else begin
         o_viol_s = (out_dat_r > o_prev_r);
      end
      if (out_sop_r) begin
         o_len_nxt_s = LEN_ONE;
         o_sum_nxt_s = SUM_W'(out_dat_r);
         o_ord_nxt_s = 1'b0;
         o_dut_nxt_s = out_err_r;
      end else begin
         o_len_nxt_s = len_inc(o_len_r);
         o_sum_nxt_s = o_sum_r + SUM_W'(out_dat_r);
         o_ord_nxt_s = o_ord_r | o_viol_s;
         o_dut_nxt_s = o_dut_r | out_err_r;
      end
      o_frame_s = out_vld_r & ((o_state_r == O_PKT) == out_sop_r);
      o_end_s   = out_vld_r & out_eop_r & ~o_frame_s;
      o_vld_s   = o_frame_s | o_end_s;
      pop_s     = o_end_s & ~fifo_empty_s;
      if (o_frame_s) begin
         o_code_s = ERR_FRAME;
      end else if (fifo_empty_s) begin
         o_code_s = ERR_UNEXP;
      end else if (o_dut_nxt_s) begin
         o_code_s = ERR_DUTERR;
      end else if (o_ord_nxt_s) begin
         o_code_s = ERR_ORDER;
      end else if (o_len_nxt_s != fifo_head_s.len) begin
         o_code_s = ERR_LEN;
      end else if (o_sum_nxt_s != fifo_head_s.sum) begin
         o_code_s = ERR_SUM;
      end else begin
         o_code_s = ERR_OK;
      end
   end

   // Output FSM: a framing fault aborts the packet without consuming a descriptor.
   always_ff @(posedge clk) begin
      if (rst) begin
         o_state_r <= O_IDLE;
         o_len_r   <= '0;
         o_sum_r   <= '0;
         o_prev_r  <= '0;
         o_ord_r   <= 1'b0;
         o_dut_r   <= 1'b0;
      end else begin
         case (o_state_r)
            O_IDLE: begin
               if (out_vld_r && out_sop_r) begin
                  o_len_r   <= o_len_nxt_s;
                  o_sum_r   <= o_sum_nxt_s;
                  o_prev_r  <= out_dat_r;
                  o_ord_r   <= o_ord_nxt_s;
                  o_dut_r   <= o_dut_nxt_s;
                  o_state_r <= out_eop_r ? O_IDLE : O_PKT;
               end
            end
            O_PKT: begin
               if (out_vld_r) begin
                  if (out_sop_r) begin
                     o_state_r <= O_IDLE;
                  end else begin
                     o_len_r   <= o_len_nxt_s;
                     o_sum_r   <= o_sum_nxt_s;
                     o_prev_r  <= out_dat_r;
                     o_ord_r   <= o_ord_nxt_s;
                     o_dut_r   <= o_dut_nxt_s;
                     o_state_r <= out_eop_r ? O_IDLE : O_PKT;
                  end
               end
            end
            default: o_state_r <= O_IDLE;
         endcase
      end
   end

   qs_chk_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (in_push_s),
      .din   (push_desc_s),
      .pop   (pop_s),
      .full  (fifo_full_s),
      .empty (fifo_empty_s),
      .head  (fifo_head_s)
   );

   // Verdict register: output verdicts win; an input error waits one slot.
   always_ff @(posedge clk) begin
      if (rst) begin
         chk_pass_r    <= 1'b0;
         chk_fail_r    <= 1'b0;
         chk_code_r    <= 3'd0;
         chk_pkt_cnt_r <= 32'd0;
         chk_busy_r    <= 1'b0;
         pend_vld_r    <= 1'b0;
         pend_code_r   <= ERR_OK;
      end else begin
         chk_pass_r <= 1'b0;
         chk_fail_r <= 1'b0;
         chk_busy_r <= ~fifo_empty_s | (o_state_r == O_PKT);
         if (o_vld_s) begin
            chk_pkt_cnt_r <= chk_pkt_cnt_r + 32'd1;
            if (o_code_s == ERR_OK) begin
               chk_pass_r <= 1'b1;
            end else begin
               chk_fail_r <= 1'b1;
               chk_code_r <= o_code_s;
            end
            if (in_err_vld_s) begin
               pend_vld_r  <= 1'b1;
               pend_code_r <= in_err_code_s;
            end
         end else if (pend_vld_r) begin
            chk_pkt_cnt_r <= chk_pkt_cnt_r + 32'd1;
            chk_fail_r    <= 1'b1;
            chk_code_r    <= pend_code_r;
            pend_vld_r    <= in_err_vld_s;
            pend_code_r   <= in_err_code_s;
         end else if (in_err_vld_s) begin
            chk_pkt_cnt_r <= chk_pkt_cnt_r + 32'd1;
            chk_fail_r    <= 1'b1;
            chk_code_r    <= in_err_code_s;
         end
      end
   end

endmodule

// File: tb/tb_qs_stream_chk.sv
// Scoreboard bench for qs_stream_chk: stimulus pushes expected verdicts,
// a negedge monitor pops and compares them against the DUT pulses.
module tb_qs_stream_chk;

   localparam logic [2:0] E_OK     = 3'd0;
   localparam logic [2:0] E_ORDER  = 3'd1;
   localparam logic [2:0] E_LEN    = 3'd2;
   localparam logic [2:0] E_SUM    = 3'd3;
   localparam logic [2:0] E_FRAME  = 3'd4;
   localparam logic [2:0] E_UNEXP  = 3'd5;
   localparam logic [2:0] E_OVF    = 3'd6;
   localparam logic [2:0] E_DUTERR = 3'd7;

   logic        clk;
   logic        rst;
   logic        in_vld, in_sop, in_eop, in_rdy_r;
   logic [31:0] in_dat;
   logic        out_vld_r, out_sop_r, out_eop_r, out_err_r;
   logic [31:0] out_dat_r;
   logic        chk_pass_r, chk_fail_r, chk_busy_r;
   logic [2:0]  chk_code_r;
   logic [31:0] chk_pkt_cnt_r;

   typedef struct {
      string       tag;
      bit          pass;
      logic [2:0]  code;
      logic [31:0] cnt;
      int          cyc;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   n_chk = 0;
   int   n_bad = 0;
   int   cyc   = 0;
   int   exp_cnt = 0;

   qs_stream_chk #(.W(32), .LEN_W(16), .DEPTH(4), .ASCEND(1'b1)) dut (
      .clk           (clk),
      .rst           (rst),
      .in_vld        (in_vld),
      .in_sop        (in_sop),
      .in_eop        (in_eop),
      .in_dat        (in_dat),
      .in_rdy_r      (in_rdy_r),
      .out_vld_r     (out_vld_r),
      .out_sop_r     (out_sop_r),
      .out_eop_r     (out_eop_r),
      .out_err_r     (out_err_r),
      .out_dat_r     (out_dat_r),
      .chk_pass_r    (chk_pass_r),
      .chk_fail_r    (chk_fail_r),
      .chk_code_r    (chk_code_r),
      .chk_pkt_cnt_r (chk_pkt_cnt_r),
      .chk_busy_r    (chk_busy_r)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
      end
   endfunction

   // Called while a beat is being driven; the verdict is due one cycle later.
   function automatic void expect_v(input string tag, input bit pass, input logic [2:0] code, input int dly);
      exp_cnt++;
      sb.push_back('{tag, pass, code, 32'(exp_cnt), cyc + dly});
   endfunction

   always @(negedge clk) begin
      if (chk_pass_r === 1'b1 || chk_fail_r === 1'b1) begin
         if (sb.size() == 0) begin
            n_chk++;
            n_bad++;
            $display("FAIL spurious_verdict actual pass=%0b fail=%0b code=%0d required none",
                     chk_pass_r, chk_fail_r, chk_code_r);
         end else begin
            mon_e = sb.pop_front();
            chk({mon_e.tag, "_pass"}, 32'(chk_pass_r), 32'(mon_e.pass));
            chk({mon_e.tag, "_fail"}, 32'(chk_fail_r), 32'(!mon_e.pass));
            if (!mon_e.pass) chk({mon_e.tag, "_code"}, 32'(chk_code_r), 32'(mon_e.code));
            chk({mon_e.tag, "_cnt"}, chk_pkt_cnt_r, mon_e.cnt);
            chk({mon_e.tag, "_cycle"}, 32'(cyc), 32'(mon_e.cyc));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic in_pkt(input int n, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, input bit ovf);
      logic [31:0] v[3];
      v[0] = a; v[1] = b; v[2] = c;
      for (int i = 0; i < n; i++) begin
         in_vld = 1'b1; in_sop = (i == 0); in_eop = (i == n - 1); in_dat = v[i];
         if (ovf && i == n - 1) expect_v("ovf", 1'b0, E_OVF, 1);
         tick();
      end
      in_vld = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
   endtask

   task automatic out_pkt(input string tag, input int n, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] c, input int err_idx,
                          input bit pass, input logic [2:0] code);
      logic [31:0] v[3];
      v[0] = a; v[1] = b; v[2] = c;
      for (int i = 0; i < n; i++) begin
         out_vld_r = 1'b1; out_sop_r = (i == 0); out_eop_r = (i == n - 1);
         out_dat_r = v[i]; out_err_r = (i == err_idx);
         if (i == n - 1) expect_v(tag, pass, code, 1);
         tick();
      end
      out_vld_r = 1'b0; out_sop_r = 1'b0; out_eop_r = 1'b0; out_err_r = 1'b0;
   endtask

   initial begin
      rst = 1'b1; in_rdy_r = 1'b1;
      in_vld = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_dat = 32'd0;
      out_vld_r = 1'b0; out_sop_r = 1'b0; out_eop_r = 1'b0; out_err_r = 1'b0; out_dat_r = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_pass", 32'(chk_pass_r), 32'd0);
      chk("rst_fail", 32'(chk_fail_r), 32'd0);
      chk("rst_code", 32'(chk_code_r), 32'd0);
      chk("rst_cnt", chk_pkt_cnt_r, 32'd0);
      chk("rst_busy", 32'(chk_busy_r), 32'd0);
      rst = 1'b0;
      tick();

      // Main function: pass, then order / length / sum faults.
      in_pkt(3, 32'd5, 32'd3, 32'd9, 1'b0);
      out_pkt("pass1", 3, 32'd3, 32'd5, 32'd9, -1, 1'b1, E_OK);
      in_pkt(3, 32'd5, 32'd3, 32'd9, 1'b0);
      out_pkt("order", 3, 32'd3, 32'd9, 32'd5, -1, 1'b0, E_ORDER);
      in_pkt(3, 32'd5, 32'd3, 32'd9, 1'b0);
      out_pkt("len", 2, 32'd3, 32'd5, 32'd0, -1, 1'b0, E_LEN);
      in_pkt(3, 32'd5, 32'd3, 32'd9, 1'b0);
      out_pkt("sum", 3, 32'd3, 32'd5, 32'd10, -1, 1'b0, E_SUM);
      out_pkt("unexp", 2, 32'd1, 32'd2, 32'd0, -1, 1'b0, E_UNEXP);
      in_pkt(3, 32'd8, 32'd4, 32'd6, 1'b0);
      out_pkt("duterr", 3, 32'd4, 32'd6, 32'd8, 1, 1'b0, E_DUTERR);

      // FIFO overflow, then in-order drain of the four surviving descriptors.
      in_pkt(1, 32'd1, 32'd0, 32'd0, 1'b0);
      in_pkt(2, 32'd2, 32'd2, 32'd0, 1'b0);
      in_pkt(1, 32'd3, 32'd0, 32'd0, 1'b0);
      in_pkt(1, 32'd4, 32'd0, 32'd0, 1'b0);
      in_pkt(1, 32'd5, 32'd0, 32'd0, 1'b1);
      tick();
      chk("busy_full", 32'(chk_busy_r), 32'd1);
      out_pkt("drain1", 1, 32'd1, 32'd0, 32'd0, -1, 1'b1, E_OK);
      out_pkt("drain2", 2, 32'd2, 32'd2, 32'd0, -1, 1'b1, E_OK);
      out_pkt("drain3", 1, 32'd3, 32'd0, 32'd0, -1, 1'b1, E_OK);
      out_pkt("drain4", 1, 32'd4, 32'd0, 32'd0, -1, 1'b1, E_OK);
      repeat (3) tick();
      chk("busy_idle", 32'(chk_busy_r), 32'd0);

      // Framing faults on each side.
      in_vld = 1'b1; in_sop = 1'b0; in_eop = 1'b0; in_dat = 32'd1;
      expect_v("in_frame", 1'b0, E_FRAME, 1);
      tick();
      in_vld = 1'b0;
      out_vld_r = 1'b1; out_sop_r = 1'b0; out_eop_r = 1'b1; out_dat_r = 32'd1;
      expect_v("out_frame", 1'b0, E_FRAME, 1);
      tick();
      out_vld_r = 1'b0; out_eop_r = 1'b0;

      // Output verdict and input error on one cycle: input error follows a cycle later.
      in_pkt(1, 32'd7, 32'd0, 32'd0, 1'b0);
      out_vld_r = 1'b1; out_sop_r = 1'b1; out_eop_r = 1'b1; out_dat_r = 32'd7;
      in_vld = 1'b1; in_sop = 1'b0; in_eop = 1'b0; in_dat = 32'd3;
      expect_v("arb_out", 1'b1, E_OK, 1);
      expect_v("arb_in", 1'b0, E_FRAME, 2);
      tick();
      out_vld_r = 1'b0; out_sop_r = 1'b0; out_eop_r = 1'b0; in_vld = 1'b0;
      tick();

      // Push and output eop together on an empty FIFO: the eop sees no descriptor.
      in_vld = 1'b1; in_sop = 1'b1; in_eop = 1'b1; in_dat = 32'd9;
      out_vld_r = 1'b1; out_sop_r = 1'b1; out_eop_r = 1'b1; out_dat_r = 32'd9;
      expect_v("same_cyc_unexp", 1'b0, E_UNEXP, 1);
      tick();
      in_vld = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
      out_vld_r = 1'b0; out_sop_r = 1'b0; out_eop_r = 1'b0;
      out_pkt("same_cyc_pass", 1, 32'd9, 32'd0, 32'd0, -1, 1'b1, E_OK);

      // Reset in the middle of an input packet.
      repeat (2) tick();
      chk("sb_pre_rst", 32'(sb.size()), 32'd0);
      in_vld = 1'b1; in_sop = 1'b1; in_eop = 1'b0; in_dat = 32'd1;
      tick();
      in_vld = 1'b0; in_sop = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      exp_cnt = 0;
      chk("post_rst_cnt", chk_pkt_cnt_r, 32'd0);
      in_pkt(1, 32'd7, 32'd0, 32'd0, 1'b0);
      out_pkt("post_rst", 1, 32'd7, 32'd0, 32'd0, -1, 1'b1, E_OK);

      repeat (5) tick();
      chk("sb_drain", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
